gng_sdiv_34_18: RTL and testbench

//   Iterative signed divider, 34-bit dividend / 18-bit divisor -> 16-bit quotient and 18-bit remainder.

---
 rtl/gng_sdiv_34_18.sv | 162 ++++++++++++++++
 tb/tb_gng_sdiv_34_18.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gng_sdiv_34_18.sv
// rtl/gng_sdiv_34_18.sv - iterative signed restoring divider, 34b / 18b -> 16b quotient, 18b remainder
module gng_sdiv_34_18 #(
    parameter int DW = 34,
    parameter int VW = 18,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          valid,
    output logic [QW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam int CW = $clog2(DW);

    // Largest positive quotient magnitude; the negative limit is one more.
    localparam logic [DW-1:0] L_QPOS_MAX = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic [DW-1:0] L_QNEG_MAX = L_QPOS_MAX + 1'b1;
    localparam logic [QW-1:0] L_SAT_POS  = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] L_SAT_NEG  = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_a_mag;      // dividend magnitude, shifted out MSB first; quotient shifted in at LSB
    logic [VW-1:0] r_b_mag;
    logic [VW-1:0] r_prem;       // partial remainder magnitude
    logic          r_a_neg;
    logic          r_b_neg;
    logic          r_b_zero;
    logic          r_valid;
    logic [QW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_dbz;
    logic          r_ovf;

    logic [DW-1:0] w_a_mag;
    logic [VW-1:0] w_b_mag;
    logic [VW:0]   w_shift;
    logic [VW+1:0] w_diff;
    logic          w_q_neg;
    logic [QW-1:0] w_q_fix;
    logic [VW-1:0] w_r_fix;
    logic          w_ovf_fix;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(W-1) without overflow.
    assign w_a_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
    assign w_b_mag = divisor[VW-1]  ? (~divisor  + 1'b1) : divisor;

    // One restoring step: bring down the next dividend bit and trial-subtract |divisor|.
    assign w_shift = {r_prem, r_a_mag[DW-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_b_mag};

    assign w_q_neg = r_a_neg ^ r_b_neg;

    // Sign correction and saturation of the finished magnitudes.
    always_comb begin
        w_q_fix   = r_a_mag[QW-1:0];
        w_r_fix   = r_a_neg ? (~r_prem + 1'b1) : r_prem;
        w_ovf_fix = 1'b0;
        if (r_b_zero) begin
            w_q_fix = r_a_neg ? L_SAT_NEG : L_SAT_POS;
            w_r_fix = '0;
        end else if (w_q_neg) begin
            if (r_a_mag > L_QNEG_MAX) begin
                w_q_fix   = L_SAT_NEG;
                w_ovf_fix = 1'b1;
            end else begin
                w_q_fix = ~r_a_mag[QW-1:0] + 1'b1;
            end
        end else if (r_a_mag > L_QPOS_MAX) begin
            w_q_fix   = L_SAT_POS;
            w_ovf_fix = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_a_mag     <= '0;
            r_b_mag     <= '0;
            r_prem      <= '0;
            r_a_neg     <= 1'b0;
            r_b_neg     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_valid     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_mag  <= w_a_mag;
                        r_b_mag  <= w_b_mag;
                        r_a_neg  <= dividend[DW-1];
                        r_b_neg  <= divisor[VW-1];
                        r_b_zero <= (divisor == '0);
                        r_prem   <= '0;
                        r_cnt    <= CW'(DW - 1);
                    end
                end
                CALC: begin
                    r_prem  <= w_diff[VW+1] ? w_shift[VW-1:0] : w_diff[VW-1:0];
                    r_a_mag <= {r_a_mag[DW-2:0], ~w_diff[VW+1]};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_dbz       <= r_b_zero;
                    r_ovf       <= r_b_zero ? 1'b0 : w_ovf_fix;
                    r_valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == CALC) || (r_state == FIX);
    assign valid     = r_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_gng_sdiv_34_18.sv
// tb/tb_gng_sdiv_34_18.sv - self-checking bench for gng_sdiv_34_18
module tb_gng_sdiv_34_18;

    typedef struct {
        logic [15:0] q;
        logic [17:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    typedef struct {
        longint a;
        longint b;
        exp_t   e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [33:0] dividend = '0;
    logic [17:0] divisor = '0;
    logic        busy;
    logic        valid;
    logic [15:0] quotient;
    logic [17:0] remainder;
    logic        dbz;
    logic        ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    gng_sdiv_34_18 dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint qt;
        longint rt;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q   = (a < 0) ? 16'h8000 : 16'h7FFF;
            e.r   = '0;
            e.dbz = 1'b1;
        end else begin
            qt = a / b;
            rt = a % b;
            if (qt > 32767) begin
                e.q = 16'h7FFF; e.ovf = 1'b1;
            end else if (qt < -32768) begin
                e.q = 16'h8000; e.ovf = 1'b1;
            end else begin
                e.q = qt[15:0];
            end
            e.r = rt[17:0];
        end
        return e;
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got valid=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("dbz", dbz, e.dbz);
                check("ovf", ovf, e.ovf);
            end
        end
    end

    task automatic drive_start(input longint a, input longint b);
        @(negedge clk);
        dividend = a[33:0];
        divisor  = b[17:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 34'h2AAAAAAAA;
        divisor  = 18'h15555;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input longint a, input longint b, input exp_t e);
        int n;
        sb.push_back(e);
        drive_start(a, b);
        check("busy_after_start", busy, 1);
        wait_valid(n);
        check("latency", n, 35);
        check("busy_in_valid", busy, 0);
    endtask

    vec_t tbl[15];

    initial begin
        int     n;
        longint a;
        longint b;
        exp_t   e;

        tbl[0]  = '{1000, 7,        '{16'd142,  18'd6,       1'b0, 1'b0}};
        tbl[1]  = '{-1000, 7,       '{16'hFF72, 18'h3FFFA,   1'b0, 1'b0}};
        tbl[2]  = '{1000, -7,       '{16'hFF72, 18'd6,       1'b0, 1'b0}};
        tbl[3]  = '{64'sd1 <<< 20, 1, '{16'h7FFF, 18'd0,     1'b0, 1'b1}};
        tbl[4]  = '{-32768, 1,      '{16'h8000, 18'd0,       1'b0, 1'b0}};
        tbl[5]  = '{-(64'sd1 <<< 33), -1, '{16'h7FFF, 18'd0, 1'b0, 1'b1}};
        tbl[6]  = '{-5, 0,          '{16'h8000, 18'd0,       1'b1, 1'b0}};
        tbl[7]  = '{5, 0,           '{16'h7FFF, 18'd0,       1'b1, 1'b0}};
        tbl[8]  = '{0, 0,           '{16'h7FFF, 18'd0,       1'b1, 1'b0}};
        tbl[9]  = '{32767, 1,       '{16'h7FFF, 18'd0,       1'b0, 1'b0}};
        tbl[10] = '{32768, 1,       '{16'h7FFF, 18'd0,       1'b0, 1'b1}};
        tbl[11] = '{-32769, 1,      '{16'h8000, 18'd0,       1'b0, 1'b1}};
        tbl[12] = '{-(64'sd1 <<< 33), -131072, '{16'h7FFF, 18'd0, 1'b0, 1'b1}};
        tbl[13] = '{7, -131072,     '{16'h0000, 18'd7,       1'b0, 1'b0}};
        tbl[14] = '{-7, 1000,       '{16'h0000, 18'h3FFF9,   1'b0, 1'b0}};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", dbz, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].e);
        end

        // Start while busy is ignored; start in the valid cycle is accepted.
        sb.push_back(model(123456789, -321));
        drive_start(123456789, -321);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 34'd999; divisor = 18'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(n);
        check("latency_ignored_start", n, 25);
        sb.push_back(model(-77777, 13));
        dividend = 34'h3FFFED02F; divisor = 18'd13; start = 1'b1;  // -77777
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_valid_width", valid, 0);
        n = 1;
        while (!valid && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_throughput", n, 36);
        repeat (40) @(posedge clk);

        // Reset in the middle of CALC aborts the operation.
        sb.push_back(model(5000, 3));
        drive_start(5000, 3);
        repeat (19) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", busy, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_valid", valid, 0);
        do_op(-1000, 7, tbl[1].e);

        // Loopback through the 16x18 multiplier product.
        for (int i = 0; i < 1200; i++) begin
            a = longint'($signed(16'($urandom)));
            b = longint'($signed(18'($urandom)));
            if (b == 0) b = 1;
            e.q = a[15:0]; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0;
            do_op(a * b, b, e);
        end

        // Random full-range operands against the truncating reference.
        for (int i = 0; i < 400; i++) begin
            a = longint'($signed(34'({$urandom, $urandom})));
            if (i % 4 == 0) a = a >>> $urandom_range(33, 10);
            b = longint'($signed(18'($urandom)));
            if (i % 3 == 0) b = b >>> $urandom_range(17, 8);
            if (i % 50 == 0) b = 0;
            do_op(a, b, model(a, b));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
